piccolo_dec: RTL
================

# piccolo_dec

Iterative Piccolo-80/128 decryption core, the inverse of the team's Piccolo encryption datapath. It accepts a 64-bit ciphertext and a run-time key over a start/ready handshake. It expands the round keys forward into a local store, then runs the inverse rounds at one round per clock. It presents the 64-bit plaintext with a one-cycle valid strobe. The block sits on the receive side of the cipher pair and is verified by loopback against the encryption core.

## Interface
- `R80`, default 25: round count for the 80-bit key.
- `R128`, default 31: round count for the 128-bit key.
- `clk`, input, 1: the single clock; all flops are rising-edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `version`, input, 1: key size; 0 selects Piccolo-80, 1 selects Piccolo-128. Sampled only on start.
- `start`, input, 1: request; accepted only when `ready` is 1.
- `ciphertext`, input, [0:63]: sampled on start.
- `keyin`, input, [0:127]: sampled on start. Piccolo-80 uses `keyin[0:79]`; `keyin[80:127]` is ignored.
- `ready`, output, 1: high in IDLE and DONE.
- `valid`, output, 1: one-cycle strobe on entry to DONE.
- `plaintext`, output, [0:63]: result; held until the next accepted start.

## Operation
- Bit 0 is the MSB. Byte and 16-bit word slicing follow the Piccolo specification.
- Let r = R80 when `version`=0 and R128 when `version`=1. Both the key and the version are latched at start.
- States: IDLE, KEYGEN, ROUND, DONE.
- IDLE → KEYGEN on `start`. In the same edge the block latches the key and version and clears the counter `cnt` (5-bit) to 0.
- Input whitening is applied in the same edge. The data register loads the ciphertext with X0 ^= wk2 and X2 ^= wk3, where X0..X3 are the 16-bit words.
- Whitening keys for Piccolo-80: wk0=k0L|k1R, wk1=k1L|k0R, wk2=k4L|k3R, wk3=k3L|k4R.
- Whitening keys for Piccolo-128: wk2=k4L|k7R, wk3=k7L|k4R.
- KEYGEN: each cycle writes round-key pair rk[2cnt], rk[2cnt+1] into the 62×16 store. These come from the forward Piccolo key schedule, including the con constants and, for 128-bit keys, the key-register permutation. `cnt` increments each cycle.
- KEYGEN → ROUND after cycle r-1, with `cnt` reloaded to 0.
- ROUND, iteration i = `cnt`: apply the F-layer with decryption keys (rk'0, rk'1).
  - i even: rk'0 = rk[2r-2i-2], rk'1 = rk[2r-2i-1].
  - i odd: the two keys are swapped.
  - X1 ^= F(X0) ^ rk'0 and X3 ^= F(X2) ^ rk'1.
  - F is the 4-bit S-box layer, then the Piccolo MixColumns over GF(2^4), then the S-box layer again.
  - For i < r-1, apply the round permutation RP: bytes (x0..x7) → (x2,x7,x4,x1,x6,x3,x0,x5).
  - The last iteration skips RP and applies output whitening: X0 ^= wk0, X2 ^= wk1.
- ROUND → DONE after iteration r-1. `plaintext` is loaded with the final state.
- DONE: `ready`=1. `start` → KEYGEN exactly as from IDLE; otherwise remain in DONE.
- `start` while busy (KEYGEN or ROUND) is ignored. No queuing.
- `version` and `keyin` changes while busy have no effect.
- Illegal state encodings return to IDLE on the next edge.

## Timing
- Reset (asynchronous, `reset`=0): state=IDLE, `cnt`=0, `ready`=1, `valid`=0, `plaintext`=64'h0, data register=0. The round-key store is not reset.
- Reset mid-operation aborts immediately. After release there is no `valid` until a new start.
- Let start be accepted at edge T. KEYGEN occupies edges T+1..T+r and ROUND occupies edges T+r+1..T+2r.
- `valid`=1 and the new `plaintext` appear in the cycle after edge T+2r. Latency is 2r+1 cycles: 51 for 80-bit, 63 for 128-bit.
- `valid` lasts exactly one cycle. `ready` is low from the cycle after acceptance until DONE.
- Back-to-back: a start in the DONE cycle (the `valid` cycle) is accepted, giving one result per 2r+1 cycles.
- `cnt` never wraps. It is compared against r-1 and reloaded on every state change.

## Test plan
- Piccolo-80 vector: `keyin[0:79]`=0x00112233445566778899, ciphertext=0x8d2bff9935f84056, version=0, start for one cycle. Required: `plaintext`=0x0123456789abcdef, with `valid` exactly 51 cycles after the start edge, for one cycle only.
- Piccolo-128 loopback: run the encryption core with key 0x00112233445566778899aabbccddeeff and plaintext 0x0123456789abcdef, then feed its ciphertext here with version=1. Required: `plaintext`=0x0123456789abcdef, with `valid` at 63 cycles.
- Busy start: pulse `start` with a different ciphertext and key at cycles 5 and 40 of an 80-bit operation. Required: both are ignored, the first result is unchanged, and `ready` stays 0 until DONE.
- Back-to-back: issue a second start (a 128-bit job) in the `valid` cycle of an 80-bit job. Required: the first plaintext is correct, the second `valid` comes 63 cycles later, and `plaintext` holds the first value until then.
- Reset mid-ROUND: assert `reset`=0 asynchronously, between clock edges, at cycle 30. Required: `ready`=1, `valid`=0 and `plaintext`=0 immediately, with no `valid` over the following 100 cycles.
- Random loopback: 500 random keys, plaintexts and versions through the encryption core and then this block. Required: every output matches its source plaintext.

Source files
------------

// File: rtl/piccolo_dec_if.sv
// Request/response bundle for the Piccolo decryption core.
// Bit 0 is the MSB of every multi-bit field.
interface piccolo_dec_if;
    logic         version;
    logic         start;
    logic [0:63]  ciphertext;
    logic [0:127] keyin;
    logic         ready;
    logic         valid;
    logic [0:63]  plaintext;

    modport master (
        output version, start, ciphertext, keyin,
        input  ready, valid, plaintext
    );

    modport slave (
        input  version, start, ciphertext, keyin,
        output ready, valid, plaintext
    );
endinterface

// File: rtl/piccolo_dec.sv
// Iterative Piccolo-80/128 decryption: forward key expansion into a 62x16 store,
// then one inverse round per clock.
module piccolo_dec #(
    parameter int unsigned R80  = 25,
    parameter int unsigned R128 = 31
) (
    input logic          clk,
    input logic          reset,
    piccolo_dec_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StKeygen, StRound, StDone} state_e;

    state_e         r_state, w_state_nx;
    logic [4:0]     r_cnt;
    logic           r_ver;
    logic [127:0]   r_key;
    logic [31:0]    r_wk01;
    logic [63:0]    r_data;
    logic [63:0]    r_pt;
    logic           r_valid;
    logic [15:0]    r_rk [62];

    logic           w_accept;
    logic [63:0]    w_ct;
    logic [127:0]   w_kin;
    logic [15:0]    w_k0, w_k1, w_k3, w_k4, w_k7;
    logic [15:0]    w_wk2, w_wk3;
    logic [4:0]     w_rounds, w_c;
    logic           w_last;
    logic [2:0]     w_m5;
    logic [31:0]    w_con, w_kpair;
    logic [127:0]   w_kperm;
    logic [5:0]     w_idx;
    logic [15:0]    w_rka, w_rkb, w_x1n, w_x3n;
    logic [63:0]    w_mix, w_rp, w_fin;

    function automatic logic [3:0] f_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'he;  4'h1: y = 4'h4;  4'h2: y = 4'hb;  4'h3: y = 4'h2;
            4'h4: y = 4'h3;  4'h5: y = 4'h8;  4'h6: y = 4'h0;  4'h7: y = 4'h9;
            4'h8: y = 4'h1;  4'h9: y = 4'ha;  4'ha: y = 4'h7;  4'hb: y = 4'hf;
            4'hc: y = 4'h6;  4'hd: y = 4'hc;  4'he: y = 4'h5;  default: y = 4'hd;
        endcase
        return y;
    endfunction

    // Multiply by x in GF(2^4) modulo x^4 + x + 1.
    function automatic logic [3:0] f_xt(input logic [3:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [15:0] f_fn(input logic [15:0] x);
        logic [3:0] s0, s1, s2, s3, y0, y1, y2, y3;
        s0 = f_sbox(x[15:12]);
        s1 = f_sbox(x[11:8]);
        s2 = f_sbox(x[7:4]);
        s3 = f_sbox(x[3:0]);
        y0 = f_xt(s0) ^ f_xt(s1) ^ s1 ^ s2 ^ s3;
        y1 = s0 ^ f_xt(s1) ^ f_xt(s2) ^ s2 ^ s3;
        y2 = s0 ^ s1 ^ f_xt(s2) ^ f_xt(s3) ^ s3;
        y3 = f_xt(s0) ^ s0 ^ s1 ^ s2 ^ f_xt(s3);
        return {f_sbox(y0), f_sbox(y1), f_sbox(y2), f_sbox(y3)};
    endfunction

    assign w_ct  = bus.ciphertext;
    assign w_kin = bus.keyin;
    assign w_k0  = w_kin[127:112];
    assign w_k1  = w_kin[111:96];
    assign w_k3  = w_kin[79:64];
    assign w_k4  = w_kin[63:48];
    assign w_k7  = w_kin[15:0];
    assign w_wk2 = {w_k4[15:8], bus.version ? w_k7[7:0] : w_k3[7:0]};
    assign w_wk3 = {bus.version ? w_k7[15:8] : w_k3[15:8], w_k4[7:0]};

    assign w_rounds = r_ver ? 5'(R128) : 5'(R80);
    assign w_last   = (r_cnt == w_rounds - 5'd1);

    // Key schedule: one constant pair and one key-word pair per KEYGEN cycle.
    assign w_c   = r_cnt + 5'd1;
    assign w_con = {w_c, 5'd0, w_c, 2'd0, w_c, 5'd0, w_c}
                 ^ (r_ver ? 32'h6547a98b : 32'h0f1e2d3c);
    assign w_m5  = 3'(r_cnt % 5'd5);
    assign w_kperm = (r_ver && r_cnt[1:0] == 2'd3)
                   ? {r_key[95:80], r_key[111:96], r_key[31:16], r_key[15:0],
                      r_key[127:112], r_key[79:64], r_key[63:48], r_key[47:32]}
                   : r_key;

    always_comb begin
        w_kpair = r_key[127:96];
        if (r_ver) begin
            case (r_cnt[1:0])
                2'd0:    w_kpair = w_kperm[95:64];
                2'd1:    w_kpair = w_kperm[63:32];
                2'd2:    w_kpair = w_kperm[31:0];
                default: w_kpair = w_kperm[127:96];
            endcase
        end else begin
            case (w_m5)
                3'd0, 3'd2: w_kpair = r_key[95:64];
                3'd1, 3'd4: w_kpair = r_key[127:96];
                default:    w_kpair = {r_key[63:48], r_key[63:48]};
            endcase
        end
    end

    // Inverse round: keys read back to front, swapped on odd iterations.
    assign w_idx = {w_rounds - 5'd1 - r_cnt, 1'b0};
    assign w_rka = r_cnt[0] ? r_rk[w_idx | 6'd1] : r_rk[w_idx];
    assign w_rkb = r_cnt[0] ? r_rk[w_idx] : r_rk[w_idx | 6'd1];
    assign w_x1n = r_data[47:32] ^ f_fn(r_data[63:48]) ^ w_rka;
    assign w_x3n = r_data[15:0] ^ f_fn(r_data[31:16]) ^ w_rkb;
    assign w_mix = {r_data[63:48], w_x1n, r_data[31:16], w_x3n};
    assign w_rp  = {w_mix[47:40], w_mix[7:0], w_mix[31:24], w_mix[55:48],
                    w_mix[15:8], w_mix[39:32], w_mix[63:56], w_mix[23:16]};
    assign w_fin = w_mix ^ {r_wk01[31:16], 16'h0, r_wk01[15:0], 16'h0};

    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        case (r_state)
            StIdle, StDone: begin
                if (bus.start) begin
                    w_state_nx = StKeygen;
                    w_accept   = 1'b1;
                end
            end
            StKeygen: if (w_last) w_state_nx = StRound;
            StRound:  if (w_last) w_state_nx = StDone;
            default:  w_state_nx = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_ver   <= 1'b0;
            r_key   <= '0;
            r_wk01  <= '0;
            r_data  <= '0;
            r_pt    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_valid <= (r_state == StRound) && w_last;
            if (w_accept) begin
                r_cnt  <= '0;
                r_ver  <= bus.version;
                r_key  <= w_kin;
                r_wk01 <= {w_k0[15:8], w_k1[7:0], w_k1[15:8], w_k0[7:0]};
                r_data <= w_ct ^ {w_wk2, 16'h0, w_wk3, 16'h0};
            end else begin
                case (r_state)
                    StKeygen: begin
                        r_cnt <= w_last ? '0 : r_cnt + 5'd1;
                        r_key <= w_kperm;
                    end
                    StRound: begin
                        r_cnt  <= w_last ? '0 : r_cnt + 5'd1;
                        r_data <= w_last ? w_fin : w_rp;
                        if (w_last) r_pt <= w_fin;
                    end
                    default: r_cnt <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == StKeygen) begin
            r_rk[{r_cnt, 1'b0}] <= w_kpair[31:16] ^ w_con[31:16];
            r_rk[{r_cnt, 1'b1}] <= w_kpair[15:0] ^ w_con[15:0];
        end
    end

    assign bus.ready     = (r_state == StIdle) || (r_state == StDone);
    assign bus.valid     = r_valid;
    assign bus.plaintext = r_pt;

endmodule
